// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with sync, visible-area and frame-start strobes.
// Optional completed-frame counter is built only when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        SYNC_ACT  = 1'b0
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic        valid,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Window bounds are kept one bit wider than the counters so a 1024-wide
    // timing with zero back porch cannot alias its sync end to zero.
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic        h_wrap;
    logic        v_wrap;
    logic        h_in_sync;
    logic        v_in_sync;

    assign h_ext  = {1'b0, h_cnt};
    assign v_ext  = {1'b0, v_cnt};
    assign h_wrap = (h_ext == H_LAST);
    assign v_wrap = (v_ext == V_LAST);

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Everything below decodes the counter registers directly, so all
    // outputs describe the same raster position in the same cycle.
    assign h_in_sync = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    assign v_in_sync = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);

    assign valid       = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
    assign hsync       = h_in_sync ? SYNC_ACT : ~SYNC_ACT;
    assign vsync       = v_in_sync ? SYNC_ACT : ~SYNC_ACT;
    assign frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (pix_en && h_wrap && v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, active-high sync variant,
// and a reduced 16x10 raster used for whole-frame and frame-counter checks.
module tb_vga_timing_gen;

`ifdef VGA_FRAME_CNT_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic vga_clk = 1'b0;
    logic rst;
    logic pix_en;

    always #5 vga_clk = ~vga_clk;

    logic [9:0]  d0_h, d0_v, d1_h, d1_v, ds_h, ds_v;
    logic        d0_valid, d0_hs, d0_vs, d0_fs;
    logic        d1_valid, d1_hs, d1_vs, d1_fs;
    logic        ds_valid, ds_hs, ds_vs, ds_fs;
    logic [15:0] d0_fc, d1_fc, ds_fc;

    vga_timing_gen d0 (
        .vga_clk(vga_clk), .rst(rst), .pix_en(pix_en),
        .h_cnt(d0_h), .v_cnt(d0_v), .valid(d0_valid), .hsync(d0_hs), .vsync(d0_vs),
        .frame_start(d0_fs), .frame_cnt(d0_fc)
    );

    vga_timing_gen #(.SYNC_ACT(1'b1)) d1 (
        .vga_clk(vga_clk), .rst(rst), .pix_en(pix_en),
        .h_cnt(d1_h), .v_cnt(d1_v), .valid(d1_valid), .hsync(d1_hs), .vsync(d1_vs),
        .frame_start(d1_fs), .frame_cnt(d1_fc)
    );

    // 16 pixels x 10 lines: hsync window h=10..12, vsync window v=7..8, 160 cycles/frame
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACT(1'b0)
    ) ds (
        .vga_clk(vga_clk), .rst(rst), .pix_en(pix_en),
        .h_cnt(ds_h), .v_cnt(ds_v), .valid(ds_valid), .hsync(ds_hs), .vsync(ds_vs),
        .frame_start(ds_fs), .frame_cnt(ds_fc)
    );

    logic [39:0] d0_sig;
    assign d0_sig = {d0_h, d0_v, d0_valid, d0_hs, d0_vs, d0_fs, d0_fc};

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    initial begin
        int pos_err, valid_err, hs0_err, hs1_err, fs_err, hs0_low, hs1_high;
        int vs_err, vs_low, fs_cnt;
        logic [39:0] snap;

        rst = 1'b1;
        pix_en = 1'b0;
        repeat (3) tick();

        check("rst_h",     d0_h, 0);
        check("rst_v",     d0_v, 0);
        check("rst_valid", d0_valid, 1);
        check("rst_hsync", d0_hs, 1);
        check("rst_vsync", d0_vs, 1);
        check("rst_fs_off", d0_fs, 0);
        check("rst_fc",    d0_fc, 0);
        check("rst_hsync_act1", d1_hs, 0);

        // Release reset with pixels enabled: first post-reset cycle sits at (0,0)
        rst = 1'b0;
        pix_en = 1'b1;
        #1;
        check("post_h",     d0_h, 0);
        check("post_v",     d0_v, 0);
        check("post_valid", d0_valid, 1);
        check("post_fs",    d0_fs, 1);

        // One full line at default timing
        pos_err = 0; valid_err = 0; hs0_err = 0; hs1_err = 0; fs_err = 0;
        hs0_low = 0; hs1_high = 0;
        for (int i = 0; i < 800; i++) begin
            if (d0_h !== 10'(i) || d0_v !== 10'd0) pos_err++;
            if (d0_valid !== (i < 640)) valid_err++;
            if (d0_hs !== !(i >= 656 && i <= 751)) hs0_err++;
            if (d1_hs !== (i >= 656 && i <= 751)) hs1_err++;
            if (d0_fs !== (i == 0)) fs_err++;
            if (d0_hs === 1'b0) hs0_low++;
            if (d1_hs === 1'b1) hs1_high++;
            tick();
        end
        check("line_pos_err",    pos_err, 0);
        check("line_valid_err",  valid_err, 0);
        check("line_hsync_err",  hs0_err, 0);
        check("line_hsync_low",  hs0_low, 96);
        check("act1_hsync_err",  hs1_err, 0);
        check("act1_hsync_high", hs1_high, 96);
        check("line_fs_err",     fs_err, 0);
        check("line_wrap_h",     d0_h, 0);
        check("line_wrap_v",     d0_v, 1);
        check("line2_fs",        d0_fs, 0);
        // 800 cycles is exactly five small frames
        check("small_5f_h",  ds_h, 0);
        check("small_5f_v",  ds_v, 0);
        check("small_5f_fc", ds_fc, FC ? 5 : 0);

        // Alternating pix_en: advance only on enabled cycles, hold everything otherwise
        for (int p = 0; p < 4; p++) begin
            pix_en = 1'b1;
            tick();
            check("tog_adv_h", d0_h, p + 1);
            pix_en = 1'b0;
            #1;
            snap = d0_sig;
            tick();
            check("tog_hold_all", d0_sig, snap);
        end
        check("tog_v",       d0_v, 1);
        check("tog_small_h", ds_h, 4);

        // Move the small raster to mid-frame (h=5, v=4), then reset with pix_en high
        pix_en = 1'b1;
        repeat (65) tick();
        check("mid_small_h",  ds_h, 5);
        check("mid_small_v",  ds_v, 4);
        check("mid_d0_h",     d0_h, 69);
        check("mid_small_fc", ds_fc, FC ? 5 : 0);
        rst = 1'b1;
        tick();
        check("midrst_d0_h",    d0_h, 0);
        check("midrst_d0_v",    d0_v, 0);
        check("midrst_small_h", ds_h, 0);
        check("midrst_small_v", ds_v, 0);
        check("midrst_small_fc", ds_fc, 0);
        rst = 1'b0;
        #1;

        // One whole small frame
        pos_err = 0; valid_err = 0; hs0_err = 0; vs_err = 0; vs_low = 0; fs_cnt = 0;
        for (int i = 0; i < 160; i++) begin
            if (ds_h !== 10'(i % 16) || ds_v !== 10'(i / 16)) pos_err++;
            if (ds_valid !== ((i % 16) < 8 && (i / 16) < 6)) valid_err++;
            if (ds_hs !== !((i % 16) >= 10 && (i % 16) <= 12)) hs0_err++;
            if (ds_vs !== !((i / 16) == 7 || (i / 16) == 8)) vs_err++;
            if (ds_vs === 1'b0) vs_low++;
            if (ds_fs === 1'b1) fs_cnt++;
            tick();
        end
        check("frame_pos_err",   pos_err, 0);
        check("frame_valid_err", valid_err, 0);
        check("frame_hsync_err", hs0_err, 0);
        check("frame_vsync_err", vs_err, 0);
        check("frame_vsync_low", vs_low, 32);
        check("frame_fs_count",  fs_cnt, 1);
        check("frame_end_h",     ds_h, 0);
        check("frame_end_v",     ds_v, 0);
        check("frame_end_fc",    ds_fc, FC ? 1 : 0);
        check("frame_d0_h",      d0_h, 160);
        check("frame_d0_v",      d0_v, 0);

        repeat (160) tick();
        check("frame2_fc",    ds_fc, FC ? 2 : 0);
        check("frame2_d0_fc", d0_fc, 0);
        check("frame2_fs",    ds_fs, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
